reserved_parking_entry: RTL

Entry-side controller for the reserved (per-flat) parking area. It pairs with the reserved exit path. It owns the reserved-slot occupancy register, one bit per flat. Entry requests arrive over a valid/ready handshake. Each request is checked against the register, the slot is marked occupied, and the gate is held open for a fixed number of cycles. Exit clears arrive on a strobe port, so entry and exit share one consistent occupancy view and one occupancy count.

---
 rtl/reserved_parking_entry.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/reserved_parking_entry.sv
// rtl/reserved_parking_entry.sv - reserved parking entry controller with shared occupancy register
`ifndef PARKING_SLOTS
`define PARKING_SLOTS 8
`endif

module reserved_parking_entry #(
    parameter int N           = `PARKING_SLOTS,
    parameter int GATE_CYCLES = 4,
    localparam int W          = $clog2(N + 1),
    localparam int CW         = $clog2(N + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic [W-1:0]  req_flat,
    output logic          req_ready,
    output logic          resp_valid,
    output logic [1:0]    resp_code,
    output logic [W-1:0]  resp_flat,
    output logic          gate_open,
    input  logic          exit_valid,
    input  logic [W-1:0]  exit_flat,
    output logic          exit_ok,
    output logic          exit_err,
    output logic [N:0]    occ_map,
    output logic [CW-1:0] occ_count
);

    localparam int        GW      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [W:0] N_EXT  = (W + 1)'(N);
    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_GRANTED  = 2'b01;
    localparam logic [1:0] CODE_OCCUPIED = 2'b10;
    localparam logic [1:0] CODE_INVALID  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_GATE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    flat_q, flat_d;
    logic [GW-1:0]   gate_cnt_q, gate_cnt_d;
    logic [N:0]      occ_q, occ_d;
    logic [CW-1:0]   count_q, count_d;
    logic            resp_valid_q, resp_valid_d;
    logic [1:0]      resp_code_q, resp_code_d;
    logic [W-1:0]    resp_flat_q, resp_flat_d;
    logic            exit_ok_q, exit_ok_d;
    logic            exit_err_q, exit_err_d;

    logic [N:0]      exit_sel;
    logic [N:0]      req_sel;
    logic [N:0]      occ_after_exit;
    logic            exit_hit;
    logic            req_in_range;
    logic            req_taken;
    logic            grant;

    // One-hot decode of both flat numbers; flats above N decode to all zeros,
    // so an out-of-range exit can never hit a slot.
    always_comb begin
        exit_sel = '0;
        req_sel  = '0;
        for (int k = 0; k <= N; k++) begin
            exit_sel[k] = (exit_flat == W'(k));
            req_sel[k]  = (flat_q == W'(k));
        end
    end

    // Exit is applied before the entry check so a same-cycle exit frees the slot.
    always_comb begin
        exit_hit       = exit_valid && |(occ_q & exit_sel);
        occ_after_exit = exit_hit ? (occ_q & ~exit_sel) : occ_q;
        req_in_range   = ({1'b0, flat_q} <= N_EXT);
        req_taken      = |(occ_after_exit & req_sel);
        grant          = (state_q == S_CHECK) && req_in_range && !req_taken;
    end

    // Next-state, occupancy, count and response logic.
    always_comb begin
        state_d      = state_q;
        flat_d       = flat_q;
        gate_cnt_d   = gate_cnt_q;
        occ_d        = occ_after_exit;
        count_d      = count_q + CW'(grant) - CW'(exit_hit);
        resp_valid_d = 1'b0;
        resp_code_d  = CODE_NONE;
        resp_flat_d  = '0;
        exit_ok_d    = exit_hit;
        exit_err_d   = exit_valid && !exit_hit;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    flat_d  = req_flat;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                resp_valid_d = 1'b1;
                resp_flat_d  = flat_q;
                if (!req_in_range) begin
                    resp_code_d = CODE_INVALID;
                    state_d     = S_IDLE;
                end else if (req_taken) begin
                    resp_code_d = CODE_OCCUPIED;
                    state_d     = S_IDLE;
                end else begin
                    resp_code_d = CODE_GRANTED;
                    occ_d       = occ_after_exit | req_sel;
                    gate_cnt_d  = GATE_LOAD;
                    state_d     = S_GATE;
                end
            end
            S_GATE: begin
                if (gate_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops the gate and all occupancy at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            flat_q       <= '0;
            gate_cnt_q   <= '0;
            occ_q        <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= CODE_NONE;
            resp_flat_q  <= '0;
            exit_ok_q    <= 1'b0;
            exit_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flat_q       <= flat_d;
            gate_cnt_q   <= gate_cnt_d;
            occ_q        <= occ_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
            resp_flat_q  <= resp_flat_d;
            exit_ok_q    <= exit_ok_d;
            exit_err_q   <= exit_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign gate_open  = (state_q == S_GATE);
    assign resp_valid = resp_valid_q;
    assign resp_code  = resp_code_q;
    assign resp_flat  = resp_flat_q;
    assign exit_ok    = exit_ok_q;
    assign exit_err   = exit_err_q;
    assign occ_map    = occ_q;
    assign occ_count  = count_q;

endmodule
